// File: rtl/fsm_control_pkg.sv
// fsm_control_pkg: definitions shared by the fabric control FSM, the
// output-word counter and the testbench. These are the state encoding,
// the FIFO geometry defaults and the FIFO index ranges. Because everyone
// uses the same constants, they all decode `Estado` the same way.
package fsm_control_pkg;

    localparam int unsigned NUM_FIFOS = 8;  // supervised FIFOs
    localparam int unsigned DEPTH     = 8;  // FIFO depth, max legal high threshold
    localparam int unsigned UMB_W     = 4;  // threshold width, must hold DEPTH

    // Bit positions of the FIFOs within empty_fifos / error_fifos.
    localparam int unsigned IN_FIFO_FIRST  = 0;
    localparam int unsigned IN_FIFO_LAST   = 3;
    localparam int unsigned OUT_FIFO_FIRST = 4;
    localparam int unsigned OUT_FIFO_LAST  = 7;

    // One-hot state word. RESET is the all-zero code.
    typedef enum logic [3:0] {
        StReset  = 4'b0000,
        StInit   = 4'b0001,
        StIdle   = 4'b0010,
        StActive = 4'b0100,
        StError  = 4'b1000
    } state_e;

    // A threshold pair is usable only if low < high and high fits in the FIFO.
    function automatic logic thr_legal(logic [UMB_W-1:0] lo, logic [UMB_W-1:0] hi);
        return (lo < hi) && (hi <= UMB_W'(DEPTH));
    endfunction

endpackage

// File: rtl/fsm_control_if.sv
// fsm_control_if: the signals exchanged between the fabric control FSM and
// the rest of the switching fabric.
//   master : the fabric side. It drives init, the requested thresholds and
//            the FIFO flags, and it receives the state and the latched values.
//   slave  : the control FSM side, with the opposite directions.
interface fsm_control_if
    import fsm_control_pkg::*;
();
    logic                 init;
    logic [UMB_W-1:0]     umbral_bajo_in;
    logic [UMB_W-1:0]     umbral_alto_in;
    logic [NUM_FIFOS-1:0] empty_fifos;
    logic [NUM_FIFOS-1:0] error_fifos;
    logic [3:0]           Estado;
    logic [UMB_W-1:0]     umbral_bajo_out;
    logic [UMB_W-1:0]     umbral_alto_out;
    logic                 idle;
    logic                 error_out;
    logic [NUM_FIFOS-1:0] error_id;
    logic                 cfg_err;

    modport master (
        output init, umbral_bajo_in, umbral_alto_in, empty_fifos, error_fifos,
        input  Estado, umbral_bajo_out, umbral_alto_out, idle, error_out, error_id, cfg_err
    );

    modport slave (
        input  init, umbral_bajo_in, umbral_alto_in, empty_fifos, error_fifos,
        output Estado, umbral_bajo_out, umbral_alto_out, idle, error_out, error_id, cfg_err
    );

endinterface

// File: rtl/fsm_control.sv
// fsm_control: central control FSM for the 4-in/4-out switching fabric.
// It steps the fabric through RESET, INIT, IDLE, ACTIVE and ERROR. It also
// latches the FIFO thresholds while in INIT and records which FIFOs caused
// an error.
// Ports:
//   clk : system clock, rising edge.
//   rst : asynchronous active-high reset.
//   bus : fsm_control_if.slave.
//         Inputs : init, umbral_*_in, empty_fifos, error_fifos.
//         Outputs: Estado, umbral_*_out, idle, error_out, error_id, cfg_err.
//         Every output comes from a register or is a direct decode of one.
module fsm_control
    import fsm_control_pkg::*;
(
    input logic          clk,
    input logic          rst,
    fsm_control_if.slave bus
);

    state_e               state_q, state_d;
    logic [UMB_W-1:0]     bajo_q, bajo_d;
    logic [UMB_W-1:0]     alto_q, alto_d;
    logic [NUM_FIFOS-1:0] err_id_q, err_id_d;
    logic                 cfg_err_q, cfg_err_d;

    logic any_err;
    logic all_empty;
    logic cfg_legal;

    assign any_err   = |bus.error_fifos;
    assign all_empty = &bus.empty_fifos;
    assign cfg_legal = thr_legal(bus.umbral_bajo_in, bus.umbral_alto_in);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReset;
            bajo_q    <= '0;
            alto_q    <= '0;
            err_id_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bajo_q    <= bajo_d;
            alto_q    <= alto_d;
            err_id_q  <= err_id_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next state and next datapath values.
    always_comb begin
        state_d   = state_q;
        bajo_d    = bajo_q;
        alto_d    = alto_q;
        err_id_d  = err_id_q;
        cfg_err_d = 1'b0;
        unique case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                // Thresholds track the inputs every cycle. The value sampled
                // on the exit edge is the one that stays frozen.
                bajo_d    = bus.umbral_bajo_in;
                alto_d    = bus.umbral_alto_in;
                cfg_err_d = !cfg_legal;
                if (!bus.init && cfg_legal) begin
                    state_d = StIdle;
                end
            end
            StIdle, StActive: begin
                if (any_err) begin
                    state_d  = StError;
                    err_id_d = bus.error_fifos;
                end else if (bus.init) begin
                    state_d = StInit;
                end else if (state_q == StIdle && !all_empty) begin
                    state_d = StActive;
                end else if (state_q == StActive && all_empty) begin
                    state_d = StIdle;
                end
            end
            StError: err_id_d = err_id_q | bus.error_fifos;
            default: state_d = StReset;
        endcase
    end

    // Outputs decoded from the state register, so they change on the same
    // edge as the state.
    always_comb begin
        bus.idle      = 1'b0;
        bus.error_out = 1'b0;
        unique case (state_q)
            StIdle:  bus.idle      = 1'b1;
            StError: bus.error_out = 1'b1;
            default: ;
        endcase
    end

    assign bus.Estado          = state_q;
    assign bus.umbral_bajo_out = bajo_q;
    assign bus.umbral_alto_out = alto_q;
    assign bus.error_id        = err_id_q;
    assign bus.cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_fsm_control.sv
// tb_fsm_control: directed, table-driven bench for fsm_control. Each table
// row gives the inputs applied before one rising edge and the outputs
// expected after it. Asynchronous reset is exercised by hand-written
// sequences.
module tb_fsm_control;
    import fsm_control_pkg::*;

    logic clk;
    logic rst;

    fsm_control_if bus ();

    fsm_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       init;
        logic [3:0] bajo;
        logic [3:0] alto;
        logic [7:0] empty;
        logic [7:0] err;
        logic [3:0] e_estado;
        logic       e_idle;
        logic       e_error;
        logic       e_cfg;
        logic [3:0] e_bajo;
        logic [3:0] e_alto;
        logic [7:0] e_id;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] es, input logic id,
                             input logic er, input logic cf, input logic [3:0] lo,
                             input logic [3:0] hi, input logic [7:0] eid);
        check({tag, " Estado"}, 32'(bus.Estado), 32'(es));
        check({tag, " idle"}, 32'(bus.idle), 32'(id));
        check({tag, " error_out"}, 32'(bus.error_out), 32'(er));
        check({tag, " cfg_err"}, 32'(bus.cfg_err), 32'(cf));
        check({tag, " umbral_bajo_out"}, 32'(bus.umbral_bajo_out), 32'(lo));
        check({tag, " umbral_alto_out"}, 32'(bus.umbral_alto_out), 32'(hi));
        check({tag, " error_id"}, 32'(bus.error_id), 32'(eid));
    endtask

    task automatic add(input logic in_init, input logic [3:0] lo, input logic [3:0] hi,
                       input logic [7:0] emp, input logic [7:0] er, input logic [3:0] es,
                       input logic e_id, input logic e_er, input logic e_cf,
                       input logic [3:0] e_lo, input logic [3:0] e_hi, input logic [7:0] eid);
        vec_t v;
        v.init = in_init; v.bajo = lo; v.alto = hi; v.empty = emp; v.err = er;
        v.e_estado = es; v.e_idle = e_id; v.e_error = e_er; v.e_cfg = e_cf;
        v.e_bajo = e_lo; v.e_alto = e_hi; v.e_id = eid;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic in_init, input logic [3:0] lo, input logic [3:0] hi,
                         input logic [7:0] emp, input logic [7:0] er);
        bus.init           = in_init;
        bus.umbral_bajo_in = lo;
        bus.umbral_alto_in = hi;
        bus.empty_fifos    = emp;
        bus.error_fifos    = er;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Columns: init lo hi empty err | Estado idle err cfg lo_out hi_out id
        add(1, 0, 0, 8'hFF, 8'h00, 4'b0001, 0, 0, 0, 0, 0, 8'h00); // RESET -> INIT
        add(1, 2, 6, 8'hFF, 8'h00, 4'b0001, 0, 0, 0, 2, 6, 8'h00); // init held
        add(0, 2, 6, 8'hFF, 8'h00, 4'b0010, 1, 0, 0, 2, 6, 8'h00); // legal -> IDLE
        add(0, 1, 7, 8'hFF, 8'h00, 4'b0010, 1, 0, 0, 2, 6, 8'h00); // frozen
        add(1, 1, 7, 8'hFF, 8'h00, 4'b0001, 0, 0, 0, 2, 6, 8'h00); // IDLE -> INIT
        add(0, 5, 5, 8'hFF, 8'h00, 4'b0001, 0, 0, 1, 5, 5, 8'h00); // lo == hi illegal
        add(0, 3, 9, 8'hFF, 8'hFF, 4'b0001, 0, 0, 1, 3, 9, 8'h00); // hi > DEPTH, err ignored
        add(0, 5, 8, 8'hFF, 8'h00, 4'b0010, 1, 0, 0, 5, 8, 8'h00); // hi == DEPTH legal
        add(1, 0, 4, 8'hFF, 8'h00, 4'b0001, 0, 0, 0, 5, 8, 8'h00); // back to INIT
        add(0, 0, 4, 8'hFF, 8'h00, 4'b0010, 1, 0, 0, 0, 4, 8'h00); // lo == 0 legal
        add(0, 0, 4, 8'hFE, 8'h00, 4'b0100, 0, 0, 0, 0, 4, 8'h00); // IDLE -> ACTIVE
        add(0, 0, 4, 8'hFE, 8'h00, 4'b0100, 0, 0, 0, 0, 4, 8'h00); // hold ACTIVE
        add(0, 0, 4, 8'hFF, 8'h00, 4'b0010, 1, 0, 0, 0, 4, 8'h00); // ACTIVE -> IDLE
        add(0, 0, 4, 8'h7F, 8'h00, 4'b0100, 0, 0, 0, 0, 4, 8'h00); // IDLE -> ACTIVE
        add(1, 9, 9, 8'hFF, 8'h20, 4'b1000, 0, 1, 0, 0, 4, 8'h20); // error beats init/empty
        add(0, 0, 4, 8'hFF, 8'h01, 4'b1000, 0, 1, 0, 0, 4, 8'h21); // id accumulates
        for (int i = 0; i < 5; i++) begin
            add(1, 2, 6, 8'hFF, 8'h00, 4'b1000, 0, 1, 0, 0, 4, 8'h21); // absorbing
        end

        // Reset held for 3 cycles.
        rst = 1'b1;
        drive(1, 0, 0, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 4'b0000, 0, 0, 0, 0, 0, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].init, vecs[i].bajo, vecs[i].alto, vecs[i].empty, vecs[i].err);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_estado, vecs[i].e_idle,
                      vecs[i].e_error, vecs[i].e_cfg, vecs[i].e_bajo, vecs[i].e_alto,
                      vecs[i].e_id);
        end

        // Asynchronous reset mid-ERROR takes effect before the next edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_err", 4'b0000, 0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 2, 6, 8'hFF, 8'h00);
        @(posedge clk);
        #1;
        check_all("post_err_rel", 4'b0001, 0, 0, 0, 0, 0, 8'h00);

        // Asynchronous reset mid-INIT clears the latched thresholds.
        @(negedge clk);
        drive(1, 3, 7, 8'hFF, 8'h00);
        @(posedge clk);
        #1;
        check_all("init_latch", 4'b0001, 0, 0, 0, 3, 7, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_init", 4'b0000, 0, 0, 0, 0, 0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_init_rel", 4'b0001, 0, 0, 0, 0, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
